// File: rtl/watch_pkg.sv
// Shared widths, FSM encoding and digit helpers for the watch datapath
// BCD/binary converters.
package watch_pkg;

  localparam int BCD_W    = 4;
  localparam int BIN_W    = 7;
  localparam int RDD_ITER = 7;
  localparam int BCD_MAX  = 9;
  localparam int WORK_W   = 2*BCD_W + BIN_W;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FIN,
    S_FAIL
  } rdd_state_t;

  function automatic logic digit_ok(input logic [BCD_W-1:0] d);
    return d <= BCD_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd2hex_step.sv
// One reverse double-dabble iteration on the {H, L, B} work register:
// shift right by one, then pull 3 back out of any nibble that reached 8.
module bcd2hex_step
  import watch_pkg::*;
(
  input  logic [WORK_W-1:0] din,
  output logic [WORK_W-1:0] dout
);

  logic [WORK_W-1:0] sh;
  logic [BCD_W-1:0]  h;
  logic [BCD_W-1:0]  l;

  always_comb begin
    sh = din >> 1;
    h  = sh[WORK_W-1 -: BCD_W];
    l  = sh[BIN_W +: BCD_W];
    if (h >= BCD_W'(8)) h = h - BCD_W'(3);
    if (l >= BCD_W'(8)) l = l - BCD_W'(3);
    dout = {h, l, sh[BIN_W-1:0]};
  end

endmodule

// File: rtl/bcd2hex.sv
// Sequential two-digit BCD to binary converter (reverse double-dabble,
// one iteration per clock) with a start/done handshake.
module bcd2hex
  import watch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BCD_W-1:0] bcd_h,
  input  logic [BCD_W-1:0] bcd_l,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [BIN_W-1:0] dout
);

  rdd_state_t        state;
  rdd_state_t        state_nxt;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_step;
  logic [CNT_W-1:0]  cnt;
  logic              ld;
  logic              stepping;
  logic              fin;
  logic              fail;

  bcd2hex_step u_step (
    .din  (work),
    .dout (work_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (digit_ok(bcd_h) && digit_ok(bcd_l)) ? S_SHIFT : S_FAIL;
      S_SHIFT: if (cnt == CNT_W'(RDD_ITER-1)) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      S_FAIL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ld       = (state == S_IDLE) && start;
    stepping = (state == S_SHIFT);
    fin      = (state == S_FIN);
    fail     = (state == S_FAIL);
  end

  // Handshake outputs are registered: done/err/dout update on the edge that leaves FIN/FAIL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      dout <= '0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        work <= {bcd_h, bcd_l, {BIN_W{1'b0}}};
        cnt  <= '0;
        busy <= 1'b1;
        err  <= 1'b0;
      end
      if (stepping) begin
        work <= work_step;
        cnt  <= cnt + CNT_W'(1);
      end
      if (fin) begin
        dout <= work[BIN_W-1:0];
        done <= 1'b1;
        err  <= 1'b0;
        busy <= 1'b0;
      end
      if (fail) begin
        dout <= '0;
        done <= 1'b1;
        err  <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd2hex.sv
// Self-checking bench for bcd2hex against an arithmetic model (10*H + L).
module tb_bcd2hex;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] bcd_h;
  logic [3:0] bcd_l;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] dout;

  int errors = 0;
  int checks = 0;

  bcd2hex dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd_h (bcd_h),
    .bcd_l (bcd_l),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion; poke > 0 re-asserts start so that it is sampled at edge E<poke>.
  task automatic run(input logic [3:0] h, input logic [3:0] l, input int poke);
    bit       bad;
    int       lat;
    int       exp_val;
    bad     = (h > 4'd9) || (l > 4'd9);
    lat     = bad ? 1 : 8;
    exp_val = bad ? 0 : (int'(h) * 10 + int'(l));
    @(negedge clk);
    bcd_h = h;
    bcd_l = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bcd_h = 4'($urandom);
    bcd_l = 4'($urandom);
    chk("busy_e0", busy, 1);
    chk("done_e0", done, 0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k == poke - 1) start = 1'b1;
      if (k == poke)     start = 1'b0;
      if (k < lat) begin
        chk("done_early", done, 0);
        chk("busy_mid", busy, 1);
      end
    end
    chk("done_pulse", done, 1);
    chk("err", err, bad);
    chk("dout", dout, exp_val);
    chk("busy_done", busy, 0);
    @(posedge clk);
    #1;
    chk("done_falls", done, 0);
    chk("dout_held", dout, exp_val);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    bcd_h = '0;
    bcd_l = '0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dout", dout, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);

    run(4'd9, 4'd9, 0);
    run(4'd0, 4'd0, 0);
    run(4'd1, 4'd0, 0);
    run(4'd5, 4'd9, 0);
    run(4'hA, 4'd3, 0);
    run(4'd2, 4'd4, 0);
    run(4'd3, 4'hF, 0);

    // Start during a conversion must be ignored: no second done afterwards.
    run(4'd4, 4'd2, 3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("no_second_done", done, 0);
    end

    // Reset mid-conversion, just before E4.
    @(negedge clk);
    bcd_h = 4'd4;
    bcd_l = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_dout", dout, 0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", done, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_abort_no_done", done, 0);
    end
    run(4'd7, 4'd7, 0);

    // Loopback sweep: BCD split of every value 0..99.
    for (int v = 0; v < 100; v++) run(4'(v / 10), 4'(v % 10), 0);

    for (int i = 0; i < 40; i++) run(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd2hex.md
# bcd2hex

Sequential two-digit BCD-to-binary converter; the inverse of `hex2bcd`, with the same `start`/`done` handshake. It accepts a tens digit and a units digit (00–99) and produces the 7-bit binary value using reverse double-dabble, one iteration per clock. It sits in the watch datapath wherever BCD-edited time or date fields (set-mode digits) must return to binary counters.

## Interface
Parameters:
- none; widths are fixed by shared constants (see Structure)

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  conversion request; sampled only in IDLE
- `bcd_h`  in  4  tens digit; sampled with `start`
- `bcd_l`  in  4  units digit; sampled with `start`
- `busy`  out  1  high from the sampling edge until `done` is asserted
- `done`  out  1  one-clock completion pulse
- `err`  out  1  high with `done` if either digit is greater than 9; held until the next accepted `start`
- `dout`  out  7  binary result; updated at `done` and held until the next `done`

## Operation
- Reset (async, `rst`=0): state IDLE; `busy`=0, `done`=0, `err`=0, `dout`=0; work register and iteration counter = 0.
- Working register: 15 bits, {H[3:0], L[3:0], B[6:0]}.
- IDLE: if `start`=1, latch H=`bcd_h`, L=`bcd_l`, B=0, counter=0.
  - If H>9 or L>9, go to FAIL.
  - Otherwise go to SHIFT.
  - `busy` goes high on this edge.
- SHIFT: each cycle, shift the 15-bit register right by 1 (bit 14 becomes 0). Then, for each of H and L independently, if the nibble is ≥8, subtract 3. Increment the counter.
  - After the 7th iteration, go to FIN.
- FIN (one cycle): `dout`←B, `done`=1, `err`=0, `busy`=0, then return to IDLE.
- FAIL (one cycle): `dout`←0, `done`=1, `err`=1, `busy`=0, then return to IDLE.
- `start` while not in IDLE is ignored and not queued.
- `start` held high continuously restarts a conversion on every IDLE cycle. Back-to-back conversions are legal.
- Result range is 0..99. H and L both reach 0 after 7 iterations for valid input; no overflow is possible.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- Valid input: the iterations occur on edges E1..E7. `done`=1, `dout` valid, and `busy`=0 all appear after E8 and last one cycle; `done` falls after E9. Latency is 8 clocks.
- Invalid input: `done`=1 and `err`=1 appear after E1. Latency is 1 clock.
- The earliest next `start` sample is edge E9 for valid input and E2 for invalid input (IDLE is re-entered after the `done` cycle). Throughput is 9 clocks per valid conversion.
- `busy` is high from after E0 until after E8 (or after E1 on an error).
- Reset asserted mid-conversion aborts immediately. All outputs clear, no `done` is produced, and no partial `dout` appears.
- Input digits may change after E0 without effect.

## Structure
- Shared package `watch_pkg`:
  - `BCD_W`=4, `BIN_W`=7, `RDD_ITER`=7
  - state encoding: IDLE, SHIFT, FIN, FAIL
  - `BCD_MAX`=9
- Natural sub-module: `bcd2hex_step`. It is purely combinational: one reverse double-dabble iteration (shift right plus conditional subtract-3 on both nibbles) mapping 15 bits to 15 bits. It is instantiated once in `bcd2hex`, and can be reused by any future unrolled variant.
- The top level holds the FSM, the 3-bit iteration counter, the work register, and the output registers.

## Test plan
- Reset held low, then released: all outputs 0. Pulse `start` with 9/9: `busy` high after E0, `done` pulse after E8, `dout`=0x63, `err`=0.
- 0/0 → `dout`=0x00 at E8. 1/0 → `dout`=0x0A. 5/9 → `dout`=0x3B. Each produces exactly one `done` pulse.
- `bcd_h`=0xA, `bcd_l`=3 → `done`=1 and `err`=1 after E1, `dout`=0. A following valid 2/4 → `err`=0, `dout`=0x18.
- `start` pulsed at E3 during a 4/2 conversion → ignored. A single `done` appears at E8 with `dout`=0x2A; no second `done` follows.
- `rst` low at E4 during a conversion → outputs clear immediately and no `done` ever appears. After release, a new 7/7 conversion gives 0x4D.
- Loopback: `hex2bcd` sweeps 0..99 and its BCD outputs are fed to `bcd2hex`. `dout` must equal the original value for all 100 codes, with `err` never asserted.
